// File: rtl/msk_aes_key_share_loader_if.sv
//------------------------------------------------------------------------------
// Module   : msk_aes_key_share_loader_if
// Brief    : Word-stream input and shared-key output bundle of the key loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface msk_aes_key_share_loader_if #(
    parameter int D = 2
);
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [128*D-1:0] sh_key;
    logic             key_valid;
    logic             key_ready;

    // slave: the loader itself; master: upstream word source plus downstream key consumer
    modport slave (
        input  in_data,
        input  in_valid,
        input  key_ready,
        output in_ready,
        output sh_key,
        output key_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output key_ready,
        input  in_ready,
        input  sh_key,
        input  key_valid
    );
endinterface

`default_nettype wire

// File: rtl/msk_aes_key_share_loader.sv
//------------------------------------------------------------------------------
// Module   : msk_aes_key_share_loader
// Brief    : Collects a D-share 128-bit key from a 32-bit word stream, scatters
//            it into the bit-interleaved share layout and hands it downstream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module msk_aes_key_share_loader #(
    parameter int D = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    msk_aes_key_share_loader_if.slave      bus
);

    localparam int NW = 4 * D;
    localparam int CW = $clog2(NW);
    localparam int KW = 128 * D;

    localparam logic [0:0]    c_LOAD = 1'b0;
    localparam logic [0:0]    c_FULL = 1'b1;
    localparam logic [CW-1:0] c_LAST = CW'(NW - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [KW-1:0] key_q,   key_d;

    logic w_in_ready;
    logic w_accept;
    logic w_handoff;

    // Ready is held low while rst_n is asserted even though the state already reads LOAD.
    assign w_in_ready = (state_q == c_LOAD) && rst_n;
    assign w_accept   = w_in_ready && bus.in_valid && !flush;
    assign w_handoff  = (state_q == c_FULL) && bus.key_ready && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        if (flush) begin
            state_d = c_LOAD;
            cnt_d   = '0;
            key_d   = '0;
        end else begin
            case (state_q)
                c_LOAD: begin
                    if (w_accept) begin
                        // Word w = 4*s + c: byte r of the word is key byte 4*c + r of share s.
                        for (int s = 0; s < D; s++) begin
                            for (int c = 0; c < 4; c++) begin
                                if (cnt_q == CW'(4 * s + c)) begin
                                    for (int r = 0; r < 4; r++) begin
                                        for (int b = 0; b < 8; b++) begin
                                            key_d[8*D*(4*c+r) + D*b + s] = bus.in_data[8*r + b];
                                        end
                                    end
                                end
                            end
                        end
                        if (cnt_q == c_LAST) begin
                            cnt_d   = '0;
                            state_d = c_FULL;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                c_FULL: begin
                    if (w_handoff) begin
                        key_d   = '0;
                        state_d = c_LOAD;
                    end
                end
                default: begin
                    state_d = c_LOAD;
                    cnt_d   = '0;
                    key_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_LOAD;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.key_valid = (state_q == c_FULL);
    // Partial keys never leave the block.
    assign bus.sh_key    = (state_q == c_FULL) ? key_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_msk_aes_key_share_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_msk_aes_key_share_loader
// Brief    : Directed self-checking bench for the two-share key loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_msk_aes_key_share_loader;

    localparam int D = 2;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_errors;

    msk_aes_key_share_loader_if #(.D(D)) bus ();

    msk_aes_key_share_loader #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected layout: bit 16*i + 2*b + s = bit b of byte i of share s.
    function automatic logic [255:0] interleave(input logic [127:0] k0, input logic [127:0] k1);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 8; b++) begin
                r[16*i + 2*b]     = k0[8*i + b];
                r[16*i + 2*b + 1] = k1[8*i + b];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] recombine(input logic [255:0] sh);
        logic [127:0] k;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 8; b++) begin
                k[8*i + b] = sh[16*i + 2*b] ^ sh[16*i + 2*b + 1];
            end
        end
        return k;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] k0, input logic [127:0] k1, input int w);
        logic [127:0] k;
        k = (w < 4) ? k0 : k1;
        return k[32*(w % 4) +: 32];
    endfunction

    // Drives words first..last back to back; each is accepted on the following rising edge.
    task automatic send_words(input logic [127:0] k0, input logic [127:0] k1,
                              input int first, input int last, input string tag);
        for (int w = first; w <= last; w++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = word_of(k0, k1, w);
            chk({tag, "_in_ready"}, {255'd0, bus.in_ready}, 256'd1);
            if (w == 4) chk({tag, "_partial_hidden"}, bus.sh_key, 256'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hdead_beef;
    endtask

    logic [127:0] ka0, ka1, kb0, kb1;
    logic [255:0] held;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.key_ready = 1'b0;

        #12;
        chk("rst_in_ready",  {255'd0, bus.in_ready},  256'd0);
        chk("rst_key_valid", {255'd0, bus.key_valid}, 256'd0);
        chk("rst_sh_key",    bus.sh_key,              256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {255'd0, bus.in_ready}, 256'd1);

        // Key 00..0f as share 0, share 1 all-zero; key_ready held high during load must be ignored.
        ka0 = 128'h0f0e0d0c0b0a09080706050403020100;
        ka1 = '0;
        bus.key_ready = 1'b1;
        send_words(ka0, ka1, 0, 7, "k1");
        bus.key_ready = 1'b0;
        chk("k1_key_valid", {255'd0, bus.key_valid}, 256'd1);
        chk("k1_sh_key",    bus.sh_key, interleave(ka0, ka1));
        chk("k1_byte1",     {240'd0, bus.sh_key[31:16]}, 256'h0001);
        chk("k1_byte3",     {240'd0, bus.sh_key[63:48]}, 256'h0005);
        chk("k1_byte15",    {240'd0, bus.sh_key[255:240]}, 256'h0055);
        chk("k1_recombine", {128'd0, recombine(bus.sh_key)}, {128'd0, ka0});

        // Hold in FULL with a word offered: nothing is consumed and the key stays put.
        held         = bus.sh_key;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hffff_ffff;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_in_ready",  {255'd0, bus.in_ready},  256'd0);
            chk("hold_key_valid", {255'd0, bus.key_valid}, 256'd1);
            chk("hold_sh_key",    bus.sh_key, held);
        end
        bus.in_valid  = 1'b0;
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.key_ready = 1'b0;
        chk("ho_key_valid", {255'd0, bus.key_valid}, 256'd0);
        chk("ho_sh_key",    bus.sh_key, 256'd0);
        chk("ho_in_ready",  {255'd0, bus.in_ready}, 256'd1);

        // Second key, both shares non-trivial.
        kb0 = 128'h0123456789abcdef_fedcba9876543210;
        kb1 = 128'hdeadbeef_cafef00d_13572468_a5a55a5a;
        send_words(kb0, kb1, 0, 7, "k2");
        chk("k2_sh_key",    bus.sh_key, interleave(kb0, kb1));
        chk("k2_recombine", {128'd0, recombine(bus.sh_key)}, {128'd0, kb0 ^ kb1});
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.key_ready = 1'b0;

        // Flush after 5 words of an all-ones key; the word offered with flush is dropped.
        ka0 = '1;
        ka1 = '1;
        send_words(ka0, ka1, 0, 4, "fl");
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hffff_ffff;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_key_valid", {255'd0, bus.key_valid}, 256'd0);
        kb0 = 128'h00ff00ff_0f0f0f0f_33333333_55555555;
        kb1 = 128'h80000001_00000000_12345678_0000aa00;
        send_words(kb0, kb1, 0, 7, "fl2");
        chk("fl2_key_valid", {255'd0, bus.key_valid}, 256'd1);
        chk("fl2_sh_key",    bus.sh_key, interleave(kb0, kb1));

        // Flush in FULL together with key_ready: key is dropped, back to LOAD.
        flush         = 1'b1;
        bus.key_ready = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        bus.key_ready = 1'b0;
        chk("flfull_key_valid", {255'd0, bus.key_valid}, 256'd0);
        chk("flfull_sh_key",    bus.sh_key, 256'd0);
        chk("flfull_in_ready",  {255'd0, bus.in_ready}, 256'd1);

        // Async reset after 3 words; the counter must restart from word 0.
        send_words(ka0, ka1, 0, 2, "ar");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_key_valid", {255'd0, bus.key_valid}, 256'd0);
        chk("ar_sh_key",    bus.sh_key, 256'd0);
        chk("ar_in_ready",  {255'd0, bus.in_ready}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        kb0 = 128'h11112222_33334444_55556666_77778888;
        kb1 = 128'h99990000_aaaabbbb_ccccdddd_eeeeffff;
        send_words(kb0, kb1, 0, 6, "ar2");
        chk("ar2_not_full", {255'd0, bus.key_valid}, 256'd0);
        send_words(kb0, kb1, 7, 7, "ar3");
        chk("ar3_key_valid", {255'd0, bus.key_valid}, 256'd1);
        chk("ar3_sh_key",    bus.sh_key, interleave(kb0, kb1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
